// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with 2-bit style saturating direction counters.
// Combinational lookup on the fetch PC; registered updates from resolved branches.
module btb_assoc #(
    parameter int PC_W  = 16,
    parameter int SETS  = 16,
    parameter int WAYS  = 2,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_NEW = CNT_W'(1 << (CNT_W - 1));

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [PC_W-1:0]  tgt_q   [SETS][WAYS];
    logic [CNT_W-1:0] cnt_q   [SETS][WAYS];
    logic [WAY_W-1:0] rr_q    [SETS];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [WAY_W-1:0] if_way;
    logic [PC_W-1:0]  pc_inc;

    assign if_idx = if_pc[IDX_W-1:0];
    assign if_tag = if_pc[PC_W-1:IDX_W];
    assign pc_inc = if_pc + PC_W'(1);

    always_comb begin
        if_hit = 1'b0;
        if_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[if_idx][WAY_W'(w)] && tag_q[if_idx][WAY_W'(w)] == if_tag) begin
                if_hit = 1'b1;
                if_way = WAY_W'(w);
            end
        end
    end

    assign pred_hit    = en & if_hit;
    assign pred_taken  = pred_hit & cnt_q[if_idx][if_way][CNT_W-1];
    assign pred_target = pred_taken ? tgt_q[if_idx][if_way] : pc_inc;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [WAY_W-1:0] u_way;
    logic [CNT_W-1:0] u_cnt;
    logic             u_free;
    logic [WAY_W-1:0] u_free_way;
    logic [WAY_W-1:0] u_victim;

    assign u_idx = upd_pc[IDX_W-1:0];
    assign u_tag = upd_pc[PC_W-1:IDX_W];

    // Downward scan so the lowest-numbered invalid way wins.
    always_comb begin
        u_hit      = 1'b0;
        u_way      = '0;
        u_free     = 1'b0;
        u_free_way = '0;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (valid_q[u_idx][WAY_W'(w - 1)] && tag_q[u_idx][WAY_W'(w - 1)] == u_tag) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w - 1);
            end
            if (!valid_q[u_idx][WAY_W'(w - 1)]) begin
                u_free     = 1'b1;
                u_free_way = WAY_W'(w - 1);
            end
        end
    end

    assign u_cnt    = cnt_q[u_idx][u_way];
    assign u_victim = u_free ? u_free_way : rr_q[u_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[IDX_W'(s)] <= '0;
                rr_q[IDX_W'(s)]    <= '0;
                for (int unsigned w = 0; w < WAYS; w++)
                    cnt_q[IDX_W'(s)][WAY_W'(w)] <= CNT_RST;
            end
        end else if (flush) begin
            for (int unsigned s = 0; s < SETS; s++)
                valid_q[IDX_W'(s)] <= '0;
        end else if (upd_valid && en) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (u_cnt != '1)
                        cnt_q[u_idx][u_way] <= u_cnt + CNT_W'(1);
                    tgt_q[u_idx][u_way] <= upd_target;
                end else if (u_cnt != '0) begin
                    cnt_q[u_idx][u_way] <= u_cnt - CNT_W'(1);
                end
            end else if (upd_taken) begin
                valid_q[u_idx][u_victim] <= 1'b1;
                tag_q[u_idx][u_victim]   <= u_tag;
                tgt_q[u_idx][u_victim]   <= upd_target;
                cnt_q[u_idx][u_victim]   <= CNT_NEW;
                if (!u_free && WAYS > 1)
                    rr_q[u_idx] <= rr_q[u_idx] + WAY_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed vector table followed by
// randomized traffic compared against a per-set behavioural model.
module tb_btb_assoc;
    logic        clk;
    logic        rst, en, flush;
    logic [15:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [15:0] pred_target;
    logic        upd_valid, upd_taken;
    logic [15:0] upd_pc, upd_target;

    int n_chk  = 0;
    int n_fail = 0;

    btb_assoc #(.PC_W(16), .SETS(16), .WAYS(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst, en, flush, uv;
        int upc;
        bit ut;
        int utgt, ipc;
        bit chk, eh, et;
        int etgt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit e, bit f, bit uv, int upc, bit ut, int utgt,
                                int ipc, bit c, bit eh, bit et, int etgt);
        vec_t v;
        v.rst = r; v.en = e; v.flush = f; v.uv = uv; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.ipc = ipc; v.chk = c; v.eh = eh; v.et = et; v.etgt = etgt;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(bit r, bit e, bit f, bit uv, int upc, bit ut, int utgt, int ipc);
        @(negedge clk);
        rst = r; en = e; flush = f; upd_valid = uv; upd_pc = upc[15:0];
        upd_taken = ut; upd_target = utgt[15:0]; if_pc = ipc[15:0];
        #2;
    endtask

    // Behavioural model: each set is a small array of entries plus a victim pointer.
    bit m_valid[16][2];
    int m_tag[16][2];
    int m_tgt[16][2];
    int m_cnt[16][2];
    int m_rr[16];

    function automatic void m_lookup(int pc, bit e, output bit h, output bit t, output int tg);
        int s = pc % 16;
        h = 0; t = 0; tg = (pc + 1) % 65536;
        if (!e) return;
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == pc / 16) begin
                h = 1;
                t = (m_cnt[s][w] >= 2);
                if (t) tg = m_tgt[s][w];
            end
    endfunction

    function automatic void m_step(bit r, bit e, bit f, bit uv, int upc, bit ut, int utgt);
        int s = upc % 16;
        int hw = -1;
        int fw = -1;
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                m_rr[i] = 0;
                for (int w = 0; w < 2; w++) begin m_valid[i][w] = 0; m_cnt[i][w] = 1; end
            end
            return;
        end
        if (f) begin
            for (int i = 0; i < 16; i++)
                for (int w = 0; w < 2; w++) m_valid[i][w] = 0;
            return;
        end
        if (!(uv && e)) return;
        for (int w = 0; w < 2; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == upc / 16) hw = w;
            if (!m_valid[s][w] && fw < 0) fw = w;
        end
        if (hw >= 0) begin
            if (ut) begin
                m_cnt[s][hw] = (m_cnt[s][hw] < 3) ? m_cnt[s][hw] + 1 : 3;
                m_tgt[s][hw] = utgt;
            end else begin
                m_cnt[s][hw] = (m_cnt[s][hw] > 0) ? m_cnt[s][hw] - 1 : 0;
            end
        end else if (ut) begin
            if (fw < 0) begin
                fw = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % 2;
            end
            m_valid[s][fw] = 1; m_tag[s][fw] = upc / 16;
            m_tgt[s][fw] = utgt; m_cnt[s][fw] = 2;
        end
    endfunction

    function automatic int rnd_pc();
        int pc = ($urandom_range(0, 5) << 4) | $urandom_range(0, 15);
        if ($urandom_range(0, 15) == 0) pc = pc | 16'hFFF0;
        return pc;
    endfunction

    initial begin
        rst = 1; en = 1; flush = 0; upd_valid = 0; upd_pc = '0;
        upd_taken = 0; upd_target = '0; if_pc = '0;

        //             rst en fl uv upc      ut utgt     ipc      chk h  t  tgt
        tbl.push_back(mk(1, 1, 0, 0, 'h0000, 0, 'h0000, 'h0010, 0, 0, 0, 'h0000));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0010, 1, 0, 0, 'h0011));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'hFFFF, 1, 0, 0, 'h0000));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0040, 'h0013, 1, 0, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 1, 1, 'h0040));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 0, 'h0099, 'h0013, 1, 1, 1, 'h0040));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 0, 'h0099, 'h0013, 1, 1, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 1, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0040, 'h0013, 1, 1, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0040, 'h0013, 1, 1, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0040, 'h0013, 1, 1, 1, 'h0040));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0040, 'h0013, 1, 1, 1, 'h0040));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0040, 'h0013, 1, 1, 1, 'h0040));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0050, 'h0013, 1, 1, 1, 'h0040));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 0, 'h0099, 'h0013, 1, 1, 1, 'h0050));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 1, 1, 'h0050));
        // set-conflict scenario on index 3 from an empty table
        tbl.push_back(mk(0, 1, 1, 0, 'h0000, 0, 'h0000, 'h0013, 1, 1, 1, 'h0050));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 0, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 1, 'h0003, 1, 'h0100, 'h0003, 1, 0, 0, 'h0004));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0200, 'h0003, 1, 1, 1, 'h0100));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 1, 1, 'h0200));
        tbl.push_back(mk(0, 1, 0, 1, 'h0023, 1, 'h0300, 'h0003, 1, 1, 1, 'h0100));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0003, 1, 0, 0, 'h0004));
        tbl.push_back(mk(0, 1, 0, 1, 'h0033, 1, 'h0400, 'h0023, 1, 1, 1, 'h0300));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 0, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0033, 1, 1, 1, 'h0400));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0023, 1, 1, 1, 'h0300));
        tbl.push_back(mk(0, 1, 0, 1, 'h0105, 0, 'h0500, 'h0105, 1, 0, 0, 'h0106));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0105, 1, 0, 0, 'h0106));
        // enable off / on
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0600, 'h0013, 1, 0, 0, 'h0014));
        tbl.push_back(mk(0, 0, 0, 1, 'h0023, 1, 'h0700, 'h0013, 1, 0, 0, 'h0014));
        tbl.push_back(mk(0, 0, 0, 0, 'h0000, 0, 'h0000, 'h0023, 1, 0, 0, 'h0024));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 1, 1, 'h0600));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0023, 1, 0, 0, 'h0024));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0033, 1, 1, 1, 'h0400));
        // flush beats a same-cycle update
        tbl.push_back(mk(0, 1, 1, 1, 'h0007, 1, 'h0800, 'h0013, 1, 1, 1, 'h0600));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 0, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0007, 1, 0, 0, 'h0008));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0033, 1, 0, 0, 'h0034));
        // reset mid-stream discards a pending update and clears the victim pointer
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0900, 'h0013, 1, 0, 0, 'h0014));
        tbl.push_back(mk(1, 1, 0, 1, 'h0005, 1, 'h0A00, 'h0013, 1, 1, 1, 'h0900));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0010, 1, 0, 0, 'h0011));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'hFFFF, 1, 0, 0, 'h0000));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 0, 0, 'h0014));
        tbl.push_back(mk(0, 1, 0, 1, 'h0003, 1, 'h0B00, 'h0005, 1, 0, 0, 'h0006));
        tbl.push_back(mk(0, 1, 0, 1, 'h0013, 1, 'h0C00, 'h0003, 1, 1, 1, 'h0B00));
        tbl.push_back(mk(0, 1, 0, 1, 'h0023, 1, 'h0D00, 'h0013, 1, 1, 1, 'h0C00));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0003, 1, 0, 0, 'h0004));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0013, 1, 1, 1, 'h0C00));
        tbl.push_back(mk(0, 1, 0, 0, 'h0000, 0, 'h0000, 'h0023, 1, 1, 1, 'h0D00));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].flush, tbl[i].uv, tbl[i].upc,
                  tbl[i].ut, tbl[i].utgt, tbl[i].ipc);
            if (tbl[i].chk) begin
                chk($sformatf("row%0d hit", i), 32'(pred_hit), 32'(tbl[i].eh));
                chk($sformatf("row%0d taken", i), 32'(pred_taken), 32'(tbl[i].et));
                chk($sformatf("row%0d target", i), 32'(pred_target), 32'(tbl[i].etgt));
            end
        end

        for (int c = 0; c < 1500; c++) begin
            bit r, e, f, uv, ut, h, t;
            int upc, utgt, ipc, tg;
            r    = (c == 0) || ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 49) == 0);
            e    = ($urandom_range(0, 7) != 0);
            uv   = $urandom_range(0, 1) == 1;
            ut   = ($urandom_range(0, 2) != 0);
            upc  = rnd_pc();
            utgt = int'($urandom_range(0, 65535));
            ipc  = ($urandom_range(0, 2) == 0) ? upc : rnd_pc();
            drive(r, e, f, uv, upc, ut, utgt, ipc);
            if (c > 0) begin
                m_lookup(ipc, e, h, t, tg);
                chk($sformatf("rnd%0d hit pc=%0h", c, ipc), 32'(pred_hit), 32'(h));
                chk($sformatf("rnd%0d taken pc=%0h", c, ipc), 32'(pred_taken), 32'(t));
                chk($sformatf("rnd%0d target pc=%0h", c, ipc), 32'(pred_target), 32'(tg));
            end
            m_step(r, e, f, uv, upc, ut, utgt);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
